// File: rtl/branch_predict_unit_pkg.sv
// Shared types for the branch prediction unit: branch-type encodings, PHT counter type
// and the weakly-not-taken reset value.
package branch_predict_unit_pkg;

  typedef enum logic [3:0] {
    BT_NOP  = 4'd0,
    BT_BEQ  = 4'd1,
    BT_BNE  = 4'd2,
    BT_BLEZ = 4'd3,
    BT_BGTZ = 4'd4,
    BT_BLTZ = 4'd5,
    BT_BGEZ = 4'd6,
    BT_J    = 4'd7,
    BT_JREG = 4'd8
  } bt_t;

  typedef logic [1:0] pht_cnt_t;

  localparam pht_cnt_t CNT_WEAK_NT = 2'b01;

  // Conditional branches are the only ones that train the PHT.
  function automatic logic is_cond(input bt_t t);
    return (t != BT_NOP) && (t != BT_J) && (t != BT_JREG);
  endfunction

endpackage

// File: rtl/branch_predict_unit_sat_counter2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_counter2
  import branch_predict_unit_pkg::*;
(
  input  pht_cnt_t cnt,
  input  logic     taken,
  output pht_cnt_t cnt_next
);

  always_comb begin
    cnt_next = cnt;
    if (taken) begin
      if (cnt != 2'b11) cnt_next = cnt + 2'd1;
    end else begin
      if (cnt != 2'b00) cnt_next = cnt - 2'd1;
    end
  end

endmodule

// File: rtl/branch_predict_unit.sv
// Branch predictor: PHT of 2-bit counters plus direct-mapped BTB, with EX-side resolve,
// table training and a registered redirect. Optional gshare indexing via BPU_GSHARE_EN.
module branch_predict_unit
  import branch_predict_unit_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int PHT_DEPTH = 256,
  parameter int BTB_DEPTH = 64,
  parameter int TAG_W     = 10,
  parameter int CNT_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  if_pc,
  output logic             pred_taken,
  output logic [XLEN-1:0]  pred_target,
  input  logic             ex_valid,
  input  logic [XLEN-1:0]  ex_pc,
  input  logic [3:0]       ex_branch_type,
  input  logic             ex_pred_taken,
  input  logic [XLEN-1:0]  ex_pred_target,
  input  logic             ex_actual_taken,
  input  logic [XLEN-1:0]  ex_actual_target,
  output logic             redirect,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] branch_cnt,
  output logic [CNT_W-1:0] mispredict_cnt
);

  localparam int PHT_IDX_W = $clog2(PHT_DEPTH);
  localparam int BTB_IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_LSB   = BTB_IDX_W + 2;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [XLEN-1:0]  target;
    bt_t              btype;
  } btb_entry_t;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  pht_cnt_t             pht [PHT_DEPTH];
  logic                 btb_valid [BTB_DEPTH];
  btb_entry_t           btb_mem [BTB_DEPTH];

  logic [PHT_IDX_W-1:0] if_pht_idx, ex_pht_idx;
  logic [BTB_IDX_W-1:0] if_btb_idx, ex_btb_idx;
  logic [TAG_W-1:0]     if_tag, ex_tag;
  btb_entry_t           btb_rd;
  logic                 btb_hit;

  bt_t                  ex_type;
  logic                 resolve_p0, cond_p0, mispredict_p0, btb_wr_p0;
  pht_cnt_t             pht_upd;

  logic                 redirect_p1;
  logic [XLEN-1:0]      redirect_pc_p1;

  assign if_btb_idx = if_pc[BTB_IDX_W+1:2];
  assign ex_btb_idx = ex_pc[BTB_IDX_W+1:2];
  assign if_tag     = if_pc[TAG_LSB+TAG_W-1:TAG_LSB];
  assign ex_tag     = ex_pc[TAG_LSB+TAG_W-1:TAG_LSB];

`ifdef BPU_GSHARE_EN
  // Lookup and update both hash with the current GHR; the shift lands after the edge.
  logic [PHT_IDX_W-1:0] ghr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)          ghr <= '0;
    else if (cond_p0) ghr <= {ghr[PHT_IDX_W-2:0], ex_actual_taken};
  end

  assign if_pht_idx = if_pc[PHT_IDX_W+1:2] ^ ghr;
  assign ex_pht_idx = ex_pc[PHT_IDX_W+1:2] ^ ghr;
`else
  assign if_pht_idx = if_pc[PHT_IDX_W+1:2];
  assign ex_pht_idx = ex_pc[PHT_IDX_W+1:2];
`endif

  // Stage p0: IF lookup (pre-update table state, no bypass)
  assign btb_rd      = btb_mem[if_btb_idx];
  assign btb_hit     = btb_valid[if_btb_idx] && btb_rd.valid && (btb_rd.tag == if_tag);
  assign pred_taken  = btb_hit && (pht[if_pht_idx][1] ||
                                   (btb_rd.btype == BT_J) || (btb_rd.btype == BT_JREG));
  assign pred_target = pred_taken ? btb_rd.target : if_pc + XLEN'(4);

  // Stage p0: EX resolve
  assign ex_type       = bt_t'(ex_branch_type);
  assign resolve_p0    = ex_valid && (ex_type != BT_NOP);
  assign cond_p0       = resolve_p0 && is_cond(ex_type);
  assign btb_wr_p0     = resolve_p0 && ex_actual_taken;
  assign mispredict_p0 = resolve_p0 &&
                         ((ex_pred_taken != ex_actual_taken) ||
                          (ex_actual_taken && (ex_pred_target != ex_actual_target)));

  sat_counter2 u_sat_counter2 (
    .cnt      (pht[ex_pht_idx]),
    .taken    (ex_actual_taken),
    .cnt_next (pht_upd)
  );

  for (genvar i = 0; i < PHT_DEPTH; i++) begin : g_pht
    pht_cnt_t cnt_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                          cnt_q <= CNT_WEAK_NT;
      else if (cond_p0 && (ex_pht_idx == PHT_IDX_W'(i))) cnt_q <= pht_upd;
    end
    assign pht[i] = cnt_q;
  end

  for (genvar i = 0; i < BTB_DEPTH; i++) begin : g_btb_valid
    logic valid_q;
    always_ff @(posedge clk or posedge rst) begin
      if (rst)                                            valid_q <= 1'b0;
      else if (btb_wr_p0 && (ex_btb_idx == BTB_IDX_W'(i))) valid_q <= 1'b1;
    end
    assign btb_valid[i] = valid_q;
  end

  // BTB payload needs no reset: it is only observed behind a set valid bit.
  always_ff @(posedge clk) begin
    if (btb_wr_p0) btb_mem[ex_btb_idx] <= '{valid: 1'b1, tag: ex_tag,
                                           target: ex_actual_target, btype: ex_type};
  end

  // Stage p1: registered redirect and performance counters
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      redirect_p1    <= 1'b0;
      redirect_pc_p1 <= '0;
      branch_cnt     <= '0;
      mispredict_cnt <= '0;
    end else begin
      redirect_p1 <= mispredict_p0;
      if (mispredict_p0)
        redirect_pc_p1 <= ex_actual_taken ? ex_actual_target : ex_pc + XLEN'(4);
      if (resolve_p0) begin
        branch_cnt <= sat_inc(branch_cnt);
        if (mispredict_p0) mispredict_cnt <= sat_inc(mispredict_cnt);
      end
    end
  end

  assign redirect    = redirect_p1;
  assign redirect_pc = redirect_pc_p1;

endmodule

// File: doc/branch_predict_unit.md
Name: branch_predict_unit

Overview:
Parametrised successor to the EX-stage branch judge. It adds prediction state: a pattern history table (PHT) of 2-bit saturating counters and a direct-mapped branch target buffer (BTB).
- IF side: combinational lookup produces pred_taken/pred_target for the fetch PC.
- EX side: resolves the judged outcome against the carried prediction, updates the tables and issues a registered redirect on mispredict.

Parameters:
XLEN, 32, address/data width
PHT_DEPTH, 256, PHT entries (power of 2); index = pc[log2(PHT_DEPTH)+1:2]
BTB_DEPTH, 64, BTB entries (power of 2); index = pc[log2(BTB_DEPTH)+1:2]
TAG_W, 10, BTB tag bits taken from pc directly above the BTB index
CNT_W, 32, width of the performance counters

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
if_pc  in  XLEN  fetch PC to predict
pred_taken  out  1  predicted taken (combinational from table state)
pred_target  out  XLEN  predicted target; if_pc+4 when pred_taken=0
ex_valid  in  1  EX instruction valid and not flushed
ex_pc  in  XLEN  PC of the resolving instruction
ex_branch_type  in  4  codebase BT_* encoding; BT_NOP means not a branch
ex_pred_taken  in  1  prediction carried down the pipe
ex_pred_target  in  XLEN  predicted target carried down the pipe
ex_actual_taken  in  1  branch_taken from the judge
ex_actual_target  in  XLEN  pc_branch_address from the judge
redirect  out  1  registered mispredict pulse
redirect_pc  out  XLEN  registered correct next PC
branch_cnt  out  CNT_W  resolved branches (saturating)
mispredict_cnt  out  CNT_W  mispredicts (saturating)

Behaviour:
Reset:
- All PHT counters = 2'b01 (weakly not-taken); all BTB valid bits = 0.
- redirect = 0, redirect_pc = 0; both counters = 0.

Lookup (combinational):
- BTB hit = valid && tag match.
- pred_taken = hit && (PHT[idx][1] || stored type is BT_J/BT_JREG).
- pred_target = BTB target on pred_taken, else if_pc+4 (wraps modulo 2^XLEN).

Resolve (when ex_valid && ex_branch_type != BT_NOP):
- mispredict = (ex_pred_taken != ex_actual_taken) || (ex_actual_taken && ex_pred_target != ex_actual_target).
- Next cycle, on mispredict: redirect = 1 for exactly one cycle; redirect_pc = ex_actual_taken ? ex_actual_target : ex_pc+4.
- redirect is 0 in every other cycle; redirect_pc holds its last value.

Table update (at the clock edge, resolved branches only):
- PHT: conditional types only. Increment on taken, saturating at 3; decrement on not-taken, saturating at 0. BT_J and BT_JREG leave the PHT unchanged.
- BTB: on actual taken, write {valid=1, tag, target, type}. Any existing entry at that index is overwritten (no associativity).
- BTB: on not-taken, the entry is left intact.

Counters (resolved branches only):
- branch_cnt += 1.
- mispredict_cnt += 1 on mispredict.
- Both saturate at all-ones.

Boundary cases:
- Same-cycle lookup and update of the same index: lookup returns the pre-update value; no bypass.
- ex_valid = 0 or BT_NOP: no table, counter or redirect change.
- rst asserted mid-operation: immediate clear; an in-flight redirect is dropped.

Optional Feature:
Macro BPU_GSHARE_EN.
- Defined: a global history register GHR of log2(PHT_DEPTH) bits, reset 0.
  - PHT index = pc-index XOR GHR, for both lookup and update.
  - On each resolved conditional branch, GHR shifts left inserting ex_actual_taken.
  - Lookup uses the current GHR; update uses the GHR value before the shift.
- Undefined: no GHR; PHT is indexed by PC bits only.

Decomposition:
- Shared package (or existing defines header) holds the BT_* encodings, the PHT counter typedef (2-bit), the BTB entry struct {valid, tag, target, type} and the reset constant CNT_WEAK_NT = 2'b01.
- One sub-module is natural: sat_counter2, the 2-bit saturating counter next-state function. It is instantiated in the update path.

Test Plan:
1. Reset, then lookup if_pc=0xBFC00000 -> pred_taken=0, pred_target=0xBFC00004; counters 0.
2. BT_BEQ at pc=0x80000100, actual taken to 0x80000200, ex_pred_taken=0 -> next cycle redirect=1, redirect_pc=0x80000200. After that cycle, the PHT entry = 2 and a lookup of 0x80000100 gives pred_taken=1, pred_target=0x80000200.
3. Same branch resolved taken 3 more times -> counter saturates at 3. One not-taken with ex_pred_taken=1 -> redirect_pc=0x80000104, counter = 2, prediction still taken.
4. BT_JREG at pc=0x80000300: target 0x80001000 predicted, actual 0x80002000 -> redirect with redirect_pc=0x80002000; BTB target updated; PHT unchanged.
5. Lookup and update of the same index in one cycle -> lookup shows the old entry; the next cycle shows the new one. Assert rst during a pending redirect -> redirect=0 immediately.
6. With BPU_GSHARE_EN, resolve T,N,T at one PC -> GHR=3'b101 (low bits). A lookup of the same PC indexes PHT[idx^GHR], checked against a model.
